mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 tb/tb_mem_access_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a small byte-addressed data memory.
// Checks range/alignment, drives the memory for exactly one cycle, extends load data
// and returns a held response with a fault flag. Keeps a saturating fault counter.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic              ReqSigned,
  input  logic [1:0]        ReqSize,
  input  logic [31:0]       ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] RespData,
  output logic              RespFault,
  output logic [7:0]        FaultCount,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic              MemSE,
  output logic [1:0]        MemSize,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                accept;
  logic                req_fault;
  logic                wr_q, sgn_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_fault_q;
  logic [7:0]          fault_cnt_q;
  logic [DATA_W-1:0]   load_ext;

  // Aligned in-range requests can never run past the top byte, so no wrap check is needed.
  assign req_fault = (ReqAddr[31:ADDR_W] != '0) ||
                     (ReqSize == 2'b11) ||
                     ((ReqSize == 2'b01) && ReqAddr[0]) ||
                     ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));

  assign RespData   = resp_data_q;
  assign RespFault  = resp_fault_q;
  assign FaultCount = fault_cnt_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake and memory port; everything is gated off while Reset is high.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    MemEnable    = 1'b0;
    MemReadWrite = 1'b0;
    MemSE        = 1'b0;
    MemSize      = 2'b00;
    MemAddress   = '0;
    MemDataIn    = '0;
    unique case (state_q)
      StIdle: begin
        ReqReady = !Reset;
        if (ReqValid && !Reset) begin
          accept  = 1'b1;
          state_d = req_fault ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (!Reset) begin
          MemEnable    = 1'b1;
          MemReadWrite = wr_q;
          MemSize      = size_q;
          MemAddress   = addr_q;
          MemDataIn    = data_q;
        end
        state_d = StResp;
      end
      StResp: begin
        RespValid = !Reset;
        if (RespReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sign/zero extension of the raw memory read according to the latched size.
  always_comb begin
    load_ext = MemDataOut;
    unique case (size_q)
      2'b00:   load_ext = {{(DATA_W-8){sgn_q & MemDataOut[7]}}, MemDataOut[7:0]};
      2'b01:   load_ext = {{(DATA_W-16){sgn_q & MemDataOut[15]}}, MemDataOut[15:0]};
      default: load_ext = MemDataOut;
    endcase
  end

  // Request latch, response capture and saturating fault counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_q         <= 1'b0;
      sgn_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      data_q       <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
      fault_cnt_q  <= 8'd0;
    end else begin
      if (accept) begin
        wr_q         <= ReqWrite;
        sgn_q        <= ReqSigned;
        size_q       <= ReqSize;
        addr_q       <= ReqAddr[ADDR_W-1:0];
        data_q       <= ReqData;
        resp_data_q  <= '0;
        resp_fault_q <= req_fault;
        if (req_fault && (fault_cnt_q != 8'hFF)) begin
          fault_cnt_q <= fault_cnt_q + 8'd1;
        end
      end
      if (state_q == StAccess) begin
        resp_data_q <= wr_q ? '0 : load_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner sequences and
// randomized traffic checked against a byte-array reference model.
module tb_mem_access_unit;

  logic        Clk, Reset;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqData;
  logic        RespValid, RespReady, RespFault;
  logic [31:0] RespData;
  logic [7:0]  FaultCount;
  logic        MemEnable, MemReadWrite, MemSE;
  logic [1:0]  MemSize;
  logic [8:0]  MemAddress;
  logic [31:0] MemDataIn, MemDataOut;

  mem_access_unit #(.ADDR_W(9), .DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSigned(ReqSigned),
    .ReqSize(ReqSize), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
    .RespFault(RespFault), .FaultCount(FaultCount),
    .MemEnable(MemEnable), .MemReadWrite(MemReadWrite), .MemSE(MemSE), .MemSize(MemSize),
    .MemAddress(MemAddress), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Physical memory seen by the DUT; combinational right-justified read.
  logic [7:0] phys [512] = '{default: 8'h00};

  always_comb begin
    MemDataOut = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i < (1 << MemSize)) MemDataOut[8*i +: 8] = phys[(int'(MemAddress) + i) % 512];
    end
  end

  always @(posedge Clk) begin
    if (MemEnable && MemReadWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (i < (1 << MemSize)) phys[(int'(MemAddress) + i) % 512] <= MemDataIn[8*i +: 8];
      end
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [512] = '{default: 8'h00};
  int exp_fc;
  int tests;
  int fails;

  function automatic bit model_fault(logic [1:0] sz, logic [31:0] addr);
    return (addr >= 32'd512) || (sz == 2'd3) || ((addr % (32'd1 << sz)) != 32'd0);
  endfunction

  function automatic logic [31:0] model_load(bit sgn, logic [1:0] sz, logic [31:0] addr);
    int n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
    if (sgn && (v >= (longint'(1) << (8 * n - 1)))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_store(logic [1:0] sz, logic [31:0] addr, logic [31:0] data);
    for (int i = 0; i < (1 << sz); i++) ref_mem[int'(addr) + i] = data[8*i +: 8];
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction: accept, watch the memory port, check response, retire it.
  task automatic do_req(bit wr, bit sgn, logic [1:0] sz, logic [31:0] addr, logic [31:0] data,
                        logic [31:0] exp_data, bit exp_fault, string tag);
    int edges, en_cnt;
    logic [8:0]  en_addr;
    logic        en_rw;
    logic [31:0] en_din;
    en_addr = 9'h0; en_rw = 1'b0; en_din = 32'h0;
    @(negedge Clk);
    check({tag, " ReqReady idle"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqSigned = sgn; ReqSize = sz;
    ReqAddr = addr; ReqData = data;
    @(posedge Clk); #1;
    ReqValid = 1'b0; ReqAddr = $urandom; ReqData = $urandom; ReqSize = 2'($urandom);
    ReqWrite = 1'($urandom);
    edges = 1; en_cnt = 0;
    while (!RespValid && edges < 8) begin
      if (MemEnable) begin
        en_cnt++; en_addr = MemAddress; en_rw = MemReadWrite; en_din = MemDataIn;
      end
      @(posedge Clk); #1;
      edges++;
    end
    if (MemEnable) en_cnt++;
    if (exp_fault && exp_fc < 255) exp_fc++;
    check({tag, " latency"}, 32'(edges), exp_fault ? 32'd1 : 32'd2);
    check({tag, " MemEnable cycles"}, 32'(en_cnt), exp_fault ? 32'd0 : 32'd1);
    if (!exp_fault) begin
      check({tag, " MemAddress"}, 32'(en_addr), 32'(addr[8:0]));
      check({tag, " MemReadWrite"}, 32'(en_rw), 32'(wr));
      if (wr) check({tag, " MemDataIn"}, en_din, data);
    end
    check({tag, " RespFault"}, 32'(RespFault), 32'(exp_fault));
    check({tag, " RespData"}, RespData, exp_data);
    check({tag, " FaultCount"}, 32'(FaultCount), 32'(exp_fc));
    @(negedge Clk);
    RespReady = 1'b1;
    @(posedge Clk); #1;
    RespReady = 1'b0;
    check({tag, " RespValid retired"}, 32'(RespValid), 32'd0);
    check({tag, " ReqReady after resp"}, 32'(ReqReady), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    bit          sgn;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    bit          exp_fault;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr, sgn, ef;
    logic [1:0]  sz;
    logic [31:0] addr, data, ed;
    int          r;
    tests = 0; fails = 0; exp_fc = 0;
    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSigned = 1'b0; ReqSize = 2'b00;
    ReqAddr = 32'h0; ReqData = 32'h0; RespReady = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd2, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd0, 32'h021, 32'h12345680, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 32'h021, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h021, 32'h0, 32'h00000080, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'h022, 32'hABCD8001, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 32'h022, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h013, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'd1, 32'h011, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 2'd3, 32'h000, 32'h0, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h80000000, 32'h0, 32'h0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 32'h1FC, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 2'd2, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 2'd1, 32'h022, 32'h0, 32'h00008001, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd0, 32'h022, 32'h0, 32'h00000001, 1'b0};

    // Reset state.
    repeat (3) @(posedge Clk);
    #1;
    check("reset ReqReady", 32'(ReqReady), 32'd0);
    check("reset RespValid", 32'(RespValid), 32'd0);
    check("reset MemEnable", 32'(MemEnable), 32'd0);
    check("reset FaultCount", 32'(FaultCount), 32'd0);
    check("reset RespData", RespData, 32'd0);
    check("reset RespFault", 32'(RespFault), 32'd0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    check("post reset ReqReady", 32'(ReqReady), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].wr, vecs[i].sgn, vecs[i].sz, vecs[i].addr, vecs[i].data,
             vecs[i].exp_data, vecs[i].exp_fault, $sformatf("vec%0d", i));
      if (!vecs[i].exp_fault && vecs[i].wr) model_store(vecs[i].sz, vecs[i].addr, vecs[i].data);
    end

    // Response held under backpressure; requests during RESP are ignored.
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSigned = 1'b0; ReqSize = 2'd2; ReqAddr = 32'h010;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    check("hold RespValid start", 32'(RespValid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      ReqValid = 1'b1; ReqSize = 2'd2; ReqAddr = 32'h013;
      @(posedge Clk); #1;
      check($sformatf("hold%0d RespValid", c), 32'(RespValid), 32'd1);
      check($sformatf("hold%0d RespData", c), RespData, 32'hDEADBEEF);
      check($sformatf("hold%0d ReqReady", c), 32'(ReqReady), 32'd0);
    end
    @(negedge Clk);
    ReqValid = 1'b0; RespReady = 1'b1;
    @(posedge Clk); #1;
    RespReady = 1'b0;
    check("hold release RespValid", 32'(RespValid), 32'd0);
    check("hold release ReqReady", 32'(ReqReady), 32'd1);
    check("hold FaultCount unchanged", 32'(FaultCount), 32'(exp_fc));

    // Randomized traffic against the reference model.
    for (int t = 0; t < 150; t++) begin
      wr  = 1'($urandom);
      sgn = 1'($urandom);
      sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r   = $urandom_range(0, 9);
      if (r == 0)      addr = 32'd512 + 32'($urandom_range(0, 1000));
      else if (r == 1) addr = $urandom | 32'h80000000;
      else             addr = 32'($urandom_range(0, 511));
      if (r > 3 && sz != 2'd3) addr = addr & ~((32'd1 << sz) - 32'd1);
      data = $urandom;
      ef   = model_fault(sz, addr);
      ed   = (ef || wr) ? 32'h0 : model_load(sgn, sz, addr);
      do_req(wr, sgn, sz, addr, data, ed, ef, $sformatf("rnd%0d", t));
      if (!ef && wr) model_store(sz, addr, data);
    end

    // Fault counter saturation.
    for (int k = 0; k < 256; k++) begin
      do_req(1'b0, 1'b0, 2'd2, 32'h013, 32'h0, 32'h0, 1'b1, $sformatf("sat%0d", k));
    end
    check("saturated FaultCount", 32'(FaultCount), 32'd255);

    // Reset during the access cycle of a store aborts the write.
    do_req(1'b1, 1'b0, 2'd2, 32'h040, 32'h11223344, 32'h0, 1'b0, "pre store");
    model_store(2'd2, 32'h040, 32'h11223344);
    @(negedge Clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd2; ReqAddr = 32'h040; ReqData = 32'h12345678;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    check("abort access reached", 32'(MemEnable), 32'd1);
    Reset = 1'b1;
    #1;
    check("abort MemEnable gated", 32'(MemEnable), 32'd0);
    check("abort ReqReady", 32'(ReqReady), 32'd0);
    check("abort RespValid", 32'(RespValid), 32'd0);
    @(posedge Clk); #1;
    exp_fc = 0;
    check("abort FaultCount", 32'(FaultCount), 32'd0);
    check("abort RespData", RespData, 32'd0);
    check("abort RespFault", 32'(RespFault), 32'd0);
    check("abort MemAddress", 32'(MemAddress), 32'd0);
    check("abort RespValid held", 32'(RespValid), 32'd0);
    @(negedge Clk); Reset = 1'b0;
    do_req(1'b0, 1'b0, 2'd2, 32'h040, 32'h0, model_load(1'b0, 2'd2, 32'h040), 1'b0, "post abort");
    do_req(1'b0, 1'b0, 2'd1, 32'h041, 32'h0, 32'h0, 1'b1, "post abort fault");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
